// File: rtl/muldiv_pkg.sv
// Shared op encoding, FSM state type and op-class helpers for the HI/LO unit.
package muldiv_pkg;

  localparam logic [3:0] OpNop   = 4'd0;
  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMadd  = 4'd5;
  localparam logic [3:0] OpMaddu = 4'd6;
  localparam logic [3:0] OpMsub  = 4'd7;
  localparam logic [3:0] OpMsubu = 4'd8;
  localparam logic [3:0] OpMthi  = 4'd9;
  localparam logic [3:0] OpMtlo  = 4'd10;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFinish
  } stateT;

  function automatic logic is_signed(input logic [3:0] op);
    return (op == OpMult) || (op == OpDiv) || (op == OpMadd) || (op == OpMsub);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OpDiv) || (op == OpDivu);
  endfunction

  function automatic logic is_acc(input logic [3:0] op);
    return (op == OpMadd) || (op == OpMaddu) || (op == OpMsub) || (op == OpMsubu);
  endfunction

  function automatic logic is_sub(input logic [3:0] op);
    return (op == OpMsub) || (op == OpMsubu);
  endfunction

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op >= OpMult) && (op <= OpMsubu);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative unsigned datapath: shift-add multiply or restoring divide, one step per Step.
// Multiply: {ResHi,ResLo} = MagA * MagB. Divide: ResLo = MagA / MagB, ResHi = MagA % MagB.
module muldiv_iter_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic             Step,
  input  logic             IsDiv,
  input  logic [WIDTH-1:0] MagA,
  input  logic [WIDTH-1:0] MagB,
  output logic [WIDTH-1:0] ResHi,
  output logic [WIDTH-1:0] ResLo
);

  // hiQ: product upper half / partial remainder
  // loQ: multiplier shifting out / dividend shifting out, quotient shifting in
  // opndQ: multiplicand / divisor
  logic [WIDTH-1:0] hiQ, hiD;
  logic [WIDTH-1:0] loQ, loD;
  logic [WIDTH-1:0] opndQ, opndD;
  logic             isDivQ, isDivD;

  logic [WIDTH:0] addSum;
  logic [WIDTH:0] remShift;
  logic [WIDTH:0] remDiff;
  logic           remGeq;

  // Next-state for one load or one iteration step.
  always_comb begin
    hiD    = hiQ;
    loD    = loQ;
    opndD  = opndQ;
    isDivD = isDivQ;

    addSum   = {1'b0, hiQ} + (loQ[0] ? {1'b0, opndQ} : '0);
    remShift = {hiQ, loQ[WIDTH-1]};
    remDiff  = remShift - {1'b0, opndQ};
    remGeq   = (remShift >= {1'b0, opndQ});

    if (Load) begin
      hiD    = '0;
      loD    = IsDiv ? MagA : MagB;
      opndD  = IsDiv ? MagB : MagA;
      isDivD = IsDiv;
    end else if (Step) begin
      if (isDivQ) begin
        // Remainder stays below the divisor, so the difference always fits WIDTH bits.
        hiD = remGeq ? remDiff[WIDTH-1:0] : remShift[WIDTH-1:0];
        loD = {loQ[WIDTH-2:0], remGeq};
      end else begin
        hiD = addSum[WIDTH:1];
        loD = {addSum[0], loQ[WIDTH-1:1]};
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hiQ    <= '0;
      loQ    <= '0;
      opndQ  <= '0;
      isDivQ <= 1'b0;
    end else begin
      hiQ    <= hiD;
      loQ    <= loD;
      opndQ  <= opndD;
      isDivQ <= isDivD;
    end
  end

  assign ResHi = hiQ;
  assign ResLo = loQ;

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO, with accumulate, MTHI/MTLO and flush abort.
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CntInit = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  stateT            stateQ, stateD;
  logic [CNT_W-1:0] cntQ, cntD;
  logic [3:0]       opQ, opD;
  logic             negProdQ, negProdD;  // result sign differs (product / quotient)
  logic             negRemQ, negRemD;    // dividend negative (remainder sign)
  logic             divZeroQ, divZeroD;
  logic [WIDTH-1:0] origAQ, origAD;
  logic [WIDTH-1:0] hiQ, hiD;
  logic [WIDTH-1:0] loQ, loD;
  logic             doneQ, doneD;

  logic             accept;
  logic             signA, signB;
  logic [WIDTH-1:0] magA, magB;
  logic             coreLoad, coreStep;
  logic [WIDTH-1:0] coreHi, coreLo;

  logic [2*WIDTH-1:0] prodU, prodS, accCur, accRes, mulRes;
  logic [WIDTH-1:0]   quot, rem;
  logic [2*WIDTH-1:0] finalRes;

  // Operand conditioning for the unsigned core.
  always_comb begin
    accept   = (stateQ == StIdle) && Start && !Flush;
    signA    = is_signed(Op) && OperandA[WIDTH-1];
    signB    = is_signed(Op) && OperandB[WIDTH-1];
    magA     = signA ? -OperandA : OperandA;
    magB     = signB ? -OperandB : OperandB;
    coreLoad = accept && is_multicycle(Op);
    coreStep = (stateQ == StRun) && !Flush;
  end

  muldiv_iter_core #(
    .WIDTH(WIDTH)
  ) uCore (
    .Clk  (Clk),
    .Reset(Reset),
    .Load (coreLoad),
    .Step (coreStep),
    .IsDiv(is_div(Op)),
    .MagA (magA),
    .MagB (magB),
    .ResHi(coreHi),
    .ResLo(coreLo)
  );

  // Sign fix-up and accumulate applied on the FINISH cycle.
  always_comb begin
    prodU  = {coreHi, coreLo};
    prodS  = negProdQ ? -prodU : prodU;
    accCur = {hiQ, loQ};
    accRes = is_sub(opQ) ? (accCur - prodS) : (accCur + prodS);
    mulRes = is_acc(opQ) ? accRes : prodS;
    quot   = negProdQ ? -coreLo : coreLo;
    rem    = negRemQ ? -coreHi : coreHi;
    if (is_div(opQ)) begin
      // Divide by zero returns the raw dividend in HI and all ones in LO.
      finalRes = divZeroQ ? {origAQ, {WIDTH{1'b1}}} : {rem, quot};
    end else begin
      finalRes = mulRes;
    end
  end

  // Control FSM next-state and HI/LO writes.
  always_comb begin
    stateD   = stateQ;
    cntD     = cntQ;
    opD      = opQ;
    negProdD = negProdQ;
    negRemD  = negRemQ;
    divZeroD = divZeroQ;
    origAD   = origAQ;
    hiD      = hiQ;
    loD      = loQ;
    doneD    = 1'b0;

    unique case (stateQ)
      StIdle: begin
        if (accept) begin
          if (is_multicycle(Op)) begin
            opD      = Op;
            negProdD = signA ^ signB;
            negRemD  = signA;
            divZeroD = (OperandB == '0);
            origAD   = OperandA;
            cntD     = CntInit;
            stateD   = StRun;
          end else if (Op == OpMthi) begin
            hiD = OperandA;
          end else if (Op == OpMtlo) begin
            loD = OperandA;
          end
        end
      end
      StRun: begin
        if (Flush) begin
          stateD = StIdle;
          cntD   = '0;
        end else begin
          cntD = cntQ - CntOne;
          if (cntQ == CntOne) begin
            stateD = StFinish;
          end
        end
      end
      StFinish: begin
        stateD = StIdle;
        cntD   = '0;
        if (!Flush) begin
          {hiD, loD} = finalRes;
          doneD      = 1'b1;
        end
      end
      default: begin
        stateD = StIdle;
        cntD   = '0;
      end
    endcase
  end

  // State and architectural registers; reset overrides everything.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stateQ   <= StIdle;
      cntQ     <= '0;
      opQ      <= OpNop;
      negProdQ <= 1'b0;
      negRemQ  <= 1'b0;
      divZeroQ <= 1'b0;
      origAQ   <= '0;
      hiQ      <= '0;
      loQ      <= '0;
      doneQ    <= 1'b0;
    end else begin
      stateQ   <= stateD;
      cntQ     <= cntD;
      opQ      <= opD;
      negProdQ <= negProdD;
      negRemQ  <= negRemD;
      divZeroQ <= divZeroD;
      origAQ   <= origAD;
      hiQ      <= hiD;
      loQ      <= loD;
      doneQ    <= doneD;
    end
  end

  assign Busy = (stateQ != StIdle);
  assign Done = doneQ;
  assign HI   = hiQ;
  assign LO   = loQ;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Scoreboard bench: stimulus pushes expected HI/LO, a monitor pops and checks on each Done.
module tb_muldiv_hilo_unit;

  localparam int W = 32;

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMaddu = 4'd6;
  localparam logic [3:0] OpMsub  = 4'd7;
  localparam logic [3:0] OpMthi  = 4'd9;
  localparam logic [3:0] OpMtlo  = 4'd10;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         Start;
  logic [3:0]   Op;
  logic [W-1:0] OperandA;
  logic [W-1:0] OperandB;
  logic         Flush;
  logic         Busy;
  logic         Done;
  logic [W-1:0] HI;
  logic [W-1:0] LO;

  muldiv_hilo_unit #(
    .WIDTH(W)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .Op      (Op),
    .OperandA(OperandA),
    .OperandB(OperandB),
    .Flush   (Flush),
    .Busy    (Busy),
    .Done    (Done),
    .HI      (HI),
    .LO      (LO)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           acceptCyc;
    int           tag;
  } expT;

  expT sb[$];
  expT monE;
  int  nCompared = 0;
  int  nMismatch = 0;
  int  cyc = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every Done must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (Done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious Done", {63'b0, Done}, 64'd0);
      end else begin
        monE = sb.pop_front();
        check($sformatf("latency tag%0d", monE.tag), 64'(cyc - monE.acceptCyc), 64'(W + 1));
        check($sformatf("HI tag%0d", monE.tag), {32'b0, HI}, {32'b0, monE.hi});
        check($sformatf("LO tag%0d", monE.tag), {32'b0, LO}, {32'b0, monE.lo});
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (Busy !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    if (Busy !== 1'b0) check("busy timeout", {63'b0, Busy}, 64'd0);
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push, input logic [W-1:0] eHi, input logic [W-1:0] eLo,
                       input int tag);
    expT e;
    waitIdle();
    Start    = 1'b1;
    Op       = op;
    OperandA = a;
    OperandB = b;
    if (push) begin
      e.hi        = eHi;
      e.lo        = eLo;
      e.acceptCyc = cyc + 1;
      e.tag       = tag;
      sb.push_back(e);
    end
    tick();
    Start = 1'b0;
    Op    = 4'd0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    Reset    = 1'b1;
    Start    = 1'b0;
    Flush    = 1'b0;
    Op       = 4'd0;
    OperandA = '0;
    OperandB = '0;
    repeat (3) tick();
    check("reset HI", {32'b0, HI}, 64'd0);
    check("reset LO", {32'b0, LO}, 64'd0);
    check("reset Busy", {63'b0, Busy}, 64'd0);
    check("reset Done", {63'b0, Done}, 64'd0);
    Reset = 1'b0;
    tick();

    // Multiply signed vs unsigned
    issue(OpMult, 32'hFFFF_FFFF, 32'd7, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1);
    issue(OpMultu, 32'hFFFF_FFFF, 32'd7, 1, 32'h0000_0006, 32'hFFFF_FFF9, 2);
    // Divide
    issue(OpDiv, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 3);
    issue(OpDivu, 32'd7, 32'd2, 1, 32'd1, 32'd3, 4);
    issue(OpDiv, 32'd7, 32'hFFFF_FFFE, 1, 32'd1, 32'hFFFF_FFFD, 5);
    // Divide by zero and signed overflow
    issue(OpDiv, 32'h1234_5678, 32'd0, 1, 32'h1234_5678, 32'hFFFF_FFFF, 6);
    issue(OpDivu, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF, 7);
    issue(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, 32'h8000_0000, 8);

    // MTHI/MTLO take effect after one edge with Busy low
    issue(OpMthi, 32'hA5A5_A5A5, 32'd0, 0, '0, '0, 0);
    check("MTHI value", {32'b0, HI}, 64'hA5A5_A5A5);
    check("MTHI Busy", {63'b0, Busy}, 64'd0);
    issue(OpMthi, 32'd0, 32'd0, 0, '0, '0, 0);
    check("MTHI zero", {32'b0, HI}, 64'd0);
    issue(OpMtlo, 32'hFFFF_FFFF, 32'd0, 0, '0, '0, 0);
    check("MTLO value", {32'b0, LO}, 64'hFFFF_FFFF);
    check("MTLO Busy", {63'b0, Busy}, 64'd0);
    // Accumulate
    issue(OpMaddu, 32'd1, 32'd1, 1, 32'd1, 32'd0, 9);
    issue(OpMsub, 32'd2, 32'd1, 1, 32'd0, 32'hFFFF_FFFE, 10);

    // Flush mid-run: abort, HI/LO untouched, no Done
    issue(OpMult, 32'd3, 32'd5, 0, '0, '0, 0);
    repeat (9) tick();
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    check("flush Busy", {63'b0, Busy}, 64'd0);
    check("flush Done", {63'b0, Done}, 64'd0);
    check("flush HI", {32'b0, HI}, 64'd0);
    check("flush LO", {32'b0, LO}, 64'hFFFF_FFFE);
    repeat (40) tick();

    // Flush with Start in IDLE: nothing accepted
    Start = 1'b1; Op = OpMthi; OperandA = 32'h1234_0000; Flush = 1'b1;
    tick();
    check("flush+MTHI HI", {32'b0, HI}, 64'd0);
    Op = OpMult; OperandA = 32'd3; OperandB = 32'd3;
    tick();
    Start = 1'b0; Flush = 1'b0; Op = 4'd0;
    check("flush+MULT Busy", {63'b0, Busy}, 64'd0);

    // Start while Busy is ignored
    issue(OpMult, 32'd3, 32'd5, 1, 32'd0, 32'd15, 11);
    repeat (3) tick();
    Start = 1'b1; Op = OpMultu; OperandA = 32'd9; OperandB = 32'd9;
    tick();
    Start = 1'b0; Op = 4'd0;
    waitIdle();

    // Reset mid-divide
    issue(OpDivu, 32'd100, 32'd7, 0, '0, '0, 0);
    repeat (19) tick();
    Reset = 1'b1;
    tick();
    check("midreset HI", {32'b0, HI}, 64'd0);
    check("midreset LO", {32'b0, LO}, 64'd0);
    check("midreset Busy", {63'b0, Busy}, 64'd0);
    check("midreset Done", {63'b0, Done}, 64'd0);
    Reset = 1'b0;
    tick();
    issue(OpMult, 32'd6, 32'd7, 1, 32'd0, 32'd42, 12);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    if (sb.size() != 0) check("scoreboard drain", 64'(sb.size()), 64'd0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
